// File: rtl/bus_dev_fifo.sv
// Show-ahead FIFO between a device driver (push side) and a bus port (pop side).
// Latency: a pushed word is on D_pop one cycle later; the head is always on D_pop while pndng=1.
// Backpressure: a push while full is dropped with a one-cycle ovf pulse unless a pop frees space the same cycle.
// Optional feature macro BUS_DEV_FIFO_OVF_CNT_EN adds an 8-bit saturating dropped-push counter, ovf_cnt.
module bus_dev_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [pckg_sz-9:0]         D_push,
  input  logic                       pop,
  output logic [pckg_sz-9:0]         D_pop,
  output logic                       pndng,
  output logic                       full,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       ovf
`ifdef BUS_DEV_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]                 ovf_cnt
`endif
);

  localparam int DW = pckg_sz - 8;
  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [DW-1:0] mem [depth];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          ovf_q, ovf_d;
  logic          pop_acc, push_acc, drop;
  logic [CW-1:0] remain;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Accept decisions, next pointers/count, and the next head word for the registered D_pop.
  always_comb begin
    pop_acc  = pop && (count_q != '0);
    push_acc = push && ((count_q != FULL_CNT) || pop_acc);
    drop     = push && !push_acc;
    wr_ptr_d = push_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    remain   = count_q - CW'(pop_acc);
    count_d  = remain + CW'(push_acc);
    ovf_d    = drop;
    dout_d   = dout_q;
    if (count_d != '0) begin
      // If nothing older survives this edge, the head is the word being written now.
      dout_d = (remain == '0) ? D_push : mem[rd_ptr_d];
    end
  end

  // Control state and output data register; D_pop holds its value while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array is intentionally not reset; D_pop never reads it before a push.
  always_ff @(posedge clk) begin
    if (reset && push_acc) begin
      mem[wr_ptr_q] <= D_push;
    end
  end

  assign D_pop = dout_q;
  assign pndng = (count_q != '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign ovf   = ovf_q;

`ifdef BUS_DEV_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Dropped-push counter saturates rather than wrapping.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Bench for bus_dev_fifo: depth-8 and depth-5 instances share one stimulus stream.
// Each cycle both are compared against a queue-based reference model.
// Directed scenarios first, then randomized push/pop traffic, then overflow saturation.
module tb_bus_dev_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       push;
  logic       pop;
  logic [7:0] d_push;

  logic [7:0] dpop8, dpop5;
  logic       pndng8, pndng5, full8, full5, ovf8, ovf5;
  logic [3:0] cnt8;
  logic [2:0] cnt5;
`ifdef BUS_DEV_FIFO_OVF_CNT_EN
  logic [7:0] ocnt8, ocnt5;
`endif

  bus_dev_fifo #(.pckg_sz(16), .depth(8)) u_dut8 (
    .clk(clk), .reset(reset), .push(push), .D_push(d_push), .pop(pop),
    .D_pop(dpop8), .pndng(pndng8), .full(full8), .count(cnt8), .ovf(ovf8)
`ifdef BUS_DEV_FIFO_OVF_CNT_EN
    , .ovf_cnt(ocnt8)
`endif
  );

  bus_dev_fifo #(.pckg_sz(16), .depth(5)) u_dut5 (
    .clk(clk), .reset(reset), .push(push), .D_push(d_push), .pop(pop),
    .D_pop(dpop5), .pndng(pndng5), .full(full5), .count(cnt5), .ovf(ovf5)
`ifdef BUS_DEV_FIFO_OVF_CNT_EN
    , .ovf_cnt(ocnt5)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a plain queue per instance plus the last head value shown.
  logic [7:0] mq [2][$];
  int         dep [2] = '{8, 5};
  logic [7:0] m_dout [2];
  logic       m_ovf [2];
  int         m_ocnt [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_dout[i] = 8'h00;
      m_ovf[i]  = 1'b0;
      m_ocnt[i] = 0;
    end
  endtask

  task automatic model_step(input logic p, input logic r, input logic [7:0] d);
    for (int i = 0; i < 2; i++) begin
      int n;
      bit dropped;
      n = mq[i].size();
      dropped = p && (n == dep[i]) && !r;
      m_ovf[i] = dropped;
      if (dropped && m_ocnt[i] < 255) m_ocnt[i]++;
      if (r && n > 0) void'(mq[i].pop_front());
      if (p && !dropped) mq[i].push_back(d);
      if (mq[i].size() > 0) m_dout[i] = mq[i][0];
    end
  endtask

  task automatic compare(input string tag);
    check_val({tag, ".pndng8"}, {31'd0, pndng8}, {31'd0, mq[0].size() > 0});
    check_val({tag, ".full8"},  {31'd0, full8},  {31'd0, mq[0].size() == 8});
    check_val({tag, ".cnt8"},   {28'd0, cnt8},   mq[0].size());
    check_val({tag, ".dpop8"},  {24'd0, dpop8},  {24'd0, m_dout[0]});
    check_val({tag, ".ovf8"},   {31'd0, ovf8},   {31'd0, m_ovf[0]});
    check_val({tag, ".pndng5"}, {31'd0, pndng5}, {31'd0, mq[1].size() > 0});
    check_val({tag, ".full5"},  {31'd0, full5},  {31'd0, mq[1].size() == 5});
    check_val({tag, ".cnt5"},   {29'd0, cnt5},   mq[1].size());
    check_val({tag, ".dpop5"},  {24'd0, dpop5},  {24'd0, m_dout[1]});
    check_val({tag, ".ovf5"},   {31'd0, ovf5},   {31'd0, m_ovf[1]});
`ifdef BUS_DEV_FIFO_OVF_CNT_EN
    check_val({tag, ".ocnt8"},  {24'd0, ocnt8},  m_ocnt[0]);
    check_val({tag, ".ocnt5"},  {24'd0, ocnt5},  m_ocnt[1]);
`endif
  endtask

  // One clock of stimulus: drive after the falling edge, compare at the next falling edge.
  task automatic cycle(input string tag, input logic p, input logic r, input logic [7:0] d);
    push   = p;
    pop    = r;
    d_push = d;
    @(posedge clk);
    if (reset) model_step(p, r, d);
    @(negedge clk);
    compare(tag);
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    d_push = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    compare("reset");
    reset = 1'b1;

    // Three words in, three out, in order.
    cycle("seq_push", 1'b1, 1'b0, 8'h11);
    cycle("seq_push", 1'b1, 1'b0, 8'h22);
    cycle("seq_push", 1'b1, 1'b0, 8'h33);
    check_val("seq_cnt3", {28'd0, cnt8}, 32'd3);
    repeat (3) cycle("seq_pop", 1'b0, 1'b1, 8'h00);

    // Simultaneous push/pop on an empty FIFO keeps only the push.
    cycle("empty_pp", 1'b1, 1'b1, 8'h7E);
    check_val("empty_pp_dpop", {24'd0, dpop8}, 32'h7E);
    cycle("empty_drain", 1'b0, 1'b1, 8'h00);

    // Fill, overflow push dropped, drain.
    for (int k = 0; k < 8; k++) cycle("fill_a", 1'b1, 1'b0, 8'(8'h40 + k));
    cycle("ovf_push", 1'b1, 1'b0, 8'hAA);
    check_val("ovf_pulse8", {31'd0, ovf8}, 32'd1);
    cycle("ovf_after", 1'b0, 1'b0, 8'h00);
    repeat (8) cycle("drain_a", 1'b0, 1'b1, 8'h00);

    // Full FIFO with push and pop together: both accepted, no overflow.
    for (int k = 0; k < 8; k++) cycle("fill_b", 1'b1, 1'b0, 8'(8'h60 + k));
    cycle("full_pp", 1'b1, 1'b1, 8'h5C);
    repeat (8) cycle("drain_b", 1'b0, 1'b1, 8'h00);

    // Asynchronous reset mid-operation.
    for (int k = 0; k < 5; k++) cycle("pre_rst", 1'b1, 1'b0, 8'(8'h80 + k));
    #2 reset = 1'b0;
    model_reset();
    #1 compare("rst_async");
    @(negedge clk);
    cycle("rst_hold", 1'b1, 1'b1, 8'h99);
    #2 reset = 1'b1;
    @(negedge clk);
    cycle("post_rst_pop", 1'b0, 1'b1, 8'h00);

    // Randomized traffic with shifting push/pop bias.
    for (int k = 0; k < 900; k++) begin
      int pp;
      pp = (k / 100) % 3 == 0 ? 75 : ((k / 100) % 3 == 1 ? 50 : 25);
      cycle("rand", $urandom_range(99) < pp, $urandom_range(99) < (100 - pp), 8'($urandom));
    end

    // Overflow saturation: fill then keep pushing without popping.
    for (int k = 0; k < 8; k++) cycle("fill_s", 1'b1, 1'b0, 8'($urandom));
    repeat (300) cycle("sat", 1'b1, 1'b0, 8'($urandom));
    repeat (9) cycle("drain_s", 1'b0, 1'b1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_dev_fifo.md
BUS_DEV_FIFO -- requirements
Module: bus_dev_fifo

Interface
REQ-001 Parameter pckg_sz, default 16, package size; data word width is pckg_sz-8 bits, matching the bus D_push/D_pop word.
REQ-002 Parameter depth, default 8, FIFO entries; legal range 2..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 push  input  1  driver-side write request.
REQ-006 D_push  input  pckg_sz-8  driver-side write data.
REQ-007 pop  input  1  bus-side read request from the bus DUT.
REQ-008 D_pop  output  pckg_sz-8  bus-side read data, head-of-queue.
REQ-009 pndng  output  1  high when FIFO holds at least one word.
REQ-010 full  output  1  high when count equals depth.
REQ-011 count  output  $clog2(depth+1)  number of stored words.
REQ-012 ovf  output  1  one-cycle pulse for each push dropped because full.

Function
REQ-013 The block SHALL be a show-ahead FIFO sitting between one device driver and one bus port: the driver pushes, the bus pops on pndng.
REQ-014 D_pop SHALL present the oldest stored word whenever pndng=1; no pop-to-data latency.
REQ-015 A word pushed in cycle N SHALL be visible on D_pop/pndng in cycle N+1; no same-cycle bypass.
REQ-016 pop with pndng=1 SHALL remove the head word at the clock edge; D_pop shows the next word (if any) in the following cycle.
REQ-017 pop with pndng=0 SHALL be ignored; count, pointers and D_pop unchanged.
REQ-018 push with full=0 SHALL store D_push at the write pointer and increment count.
REQ-019 push with full=1 and pop=0 SHALL drop D_push, leave contents unchanged, and pulse ovf high for exactly that following cycle.
REQ-020 push and pop together with full=1 SHALL both be accepted; count stays depth, no ovf.
REQ-021 push and pop together with count=0 SHALL accept the push only; count becomes 1.
REQ-022 push and pop together with 0<count<depth SHALL both be accepted; count unchanged.
REQ-023 Read and write pointers SHALL wrap from depth-1 to 0, including for non-power-of-two depth.
REQ-024 pndng, full and count SHALL be derived from registered state only (no combinational path from push/pop).
REQ-025 When pndng=0, D_pop SHALL hold its last driven value (no X propagation to the bus).

Reset
REQ-026 reset low SHALL immediately clear pointers and count; pndng=0, full=0, count=0, ovf=0, D_pop=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; no push or pop is honoured while reset is low.
REQ-028 Storage array contents need not be cleared; D_pop SHALL still read 0 until the first post-reset push.

Configuration
REQ-029 Macro BUS_DEV_FIFO_OVF_CNT_EN defined: add output ovf_cnt, 8 bits, counting dropped pushes, saturating at 255, cleared by reset.
REQ-030 Macro undefined: port ovf_cnt absent; drop behaviour and ovf pulse unchanged.

Verification
REQ-031 depth=8: push 0x11,0x22,0x33 on consecutive cycles, then pop x3 -> D_pop 0x11,0x22,0x33 in order, pndng falls after third pop, count 3->0.
REQ-032 Fill 8 words, push 0xAA with pop=0 -> ovf pulses one cycle, count stays 8, 0xAA never appears on D_pop; with macro ovf_cnt=1.
REQ-033 Full FIFO, push 0x5C with pop same cycle -> count stays 8, ovf=0, 0x5C emerges as ninth word popped.
REQ-034 Empty FIFO, push 0x7E and pop same cycle -> next cycle pndng=1, D_pop=0x7E, count=1.
REQ-035 Push 5 words, assert reset low between clock edges -> pndng/count/full clear immediately; after release, pop with pndng=0 has no effect.
REQ-036 Run 20 push/pop cycles through depth=5 -> pointers wrap, data order preserved, no ovf; with macro, 300 dropped pushes -> ovf_cnt=255.
